key_event_gen: RTL and testbench



---
 rtl/key_event_gen.sv | 150 +++++++++++++++
 tb/tb_key_event_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/key_event_gen.sv
// Pushbutton conditioner: two-flop sync, press/release debounce, press strobe, long-press flag.
// Define KEY_REPEAT_EN to also strobe at hold expiry and every REP_CYC cycles while held.
module key_event_gen #(
    parameter int unsigned NUM_KEYS    = 2,
    parameter int unsigned CLK_FREQ    = 50000000,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned HOLD_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 200
) (
    input  logic                clk_50M,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int unsigned DEB_CYC  = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int unsigned HOLD_CYC = CLK_FREQ / 1000 * HOLD_MS;
    localparam int unsigned REP_CYC  = CLK_FREQ / 1000 * REPEAT_MS;

    localparam int unsigned MAX_DH  = (DEB_CYC > HOLD_CYC) ? DEB_CYC : HOLD_CYC;
    localparam int unsigned MAX_CYC = (MAX_DH > REP_CYC) ? MAX_DH : REP_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StDebP,
        StPressed,
        StRepeat,
        StDebR
    } state_e;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        logic             sync1_q;
        logic             sync2_q;
        logic             pressed;
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             pulse_q;
        logic             level_q;
        logic             long_q;

        // Flops reset to released so a key held through reset must re-debounce.
        always_ff @(posedge clk_50M) begin
            if (rst) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
            end else begin
                sync1_q <= key_n[g];
                sync2_q <= sync1_q;
            end
        end

        assign pressed = ~sync2_q;

        always_ff @(posedge clk_50M) begin
            if (rst) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                unique case (state_q)
                    StIdle: begin
                        if (pressed) begin
                            state_q <= StDebP;
                            cnt_q   <= '0;
                        end
                    end
                    StDebP: begin
                        if (!pressed) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_q <= StPressed;
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                            level_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StPressed: begin
                        if (!pressed) begin
                            state_q <= StDebR;
                            cnt_q   <= '0;
                        end else if (cnt_q == HOLD_LAST) begin
                            state_q <= StRepeat;
                            cnt_q   <= '0;
                            long_q  <= 1'b1;
`ifdef KEY_REPEAT_EN
                            pulse_q <= 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (!pressed) begin
                            state_q <= StDebR;
                            cnt_q   <= '0;
`ifdef KEY_REPEAT_EN
                        end else if (cnt_q == REP_LAST) begin
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`else
                        end
`endif
                    end
                    StDebR: begin
                        // long_q doubles as the return target: set only in REPEAT or
                        // in a release debounce entered from REPEAT.
                        if (pressed) begin
                            state_q <= long_q ? StRepeat : StPressed;
                            cnt_q   <= '0;
                        end else if (cnt_q == DEB_LAST) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            level_q <= 1'b0;
                            long_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign key_pulse[g] = pulse_q;
        assign key_level[g] = level_q;
        assign key_long[g]  = long_q;
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with DEB_CYC=4, HOLD_CYC=20, REP_CYC=5.
// Edge 1 is the first rising edge sampling the new key_n value; outputs sampled 1 ns after edges.
module tb_key_event_gen;

    logic       clk_50M = 1'b0;
    logic       rst;
    logic [1:0] key_n;
    logic [1:0] key_pulse;
    logic [1:0] key_level;
    logic [1:0] key_long;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    key_event_gen #(
        .NUM_KEYS   (2),
        .CLK_FREQ   (1000),
        .DEBOUNCE_MS(4),
        .HOLD_MS    (20),
        .REPEAT_MS  (5)
    ) dut (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .key_n    (key_n),
        .key_pulse(key_pulse),
        .key_level(key_level),
        .key_long (key_long)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_50M);
        #1;
        edge_n++;
    endtask

    function automatic logic rep_pulse(input int e);
`ifdef KEY_REPEAT_EN
        return (e == 7) || (e >= 27 && ((e - 27) % 5) == 0);
`else
        return (e == 7);
`endif
    endfunction

    initial begin
        rst   = 1'b1;
        key_n = 2'b11;
        repeat (3) step();
        check_eq("rst pulse", key_pulse, 2'b00);
        check_eq("rst level", key_level, 2'b00);
        check_eq("rst long", key_long, 2'b00);
        rst = 1'b0;
        repeat (3) step();
        check_eq("idle level", key_level, 2'b00);

        // Key 0 low for 10 edges; release sample at edge 11, level drops at edge 17.
        edge_n = 0;
        key_n  = 2'b10;
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq($sformatf("t1 pulse e%0d", edge_n), key_pulse, {1'b0, edge_n == 7});
            check_eq($sformatf("t1 level e%0d", edge_n), key_level,
                     {1'b0, (edge_n >= 7) && (edge_n < 17)});
            check_eq($sformatf("t1 long e%0d", edge_n), key_long, 2'b00);
            if (edge_n == 10) key_n = 2'b11;
        end

        // Key 1 low for 3 edges: shorter than the debounce, no output.
        edge_n = 0;
        key_n  = 2'b01;
        for (int i = 0; i < 15; i++) begin
            step();
            check_eq($sformatf("t2a pulse e%0d", edge_n), key_pulse, 2'b00);
            check_eq($sformatf("t2a level e%0d", edge_n), key_level, 2'b00);
            if (edge_n == 3) key_n = 2'b11;
        end

        // Key 1 press with a 2-edge high glitch at edges 12-13; release sample at edge 20.
        edge_n = 0;
        key_n  = 2'b01;
        for (int i = 0; i < 30; i++) begin
            step();
            check_eq($sformatf("t2b pulse e%0d", edge_n), key_pulse, {edge_n == 7, 1'b0});
            check_eq($sformatf("t2b level e%0d", edge_n), key_level,
                     {(edge_n >= 7) && (edge_n < 26), 1'b0});
            check_eq($sformatf("t2b long e%0d", edge_n), key_long, 2'b00);
            if (edge_n == 11) key_n = 2'b11;
            if (edge_n == 13) key_n = 2'b01;
            if (edge_n == 19) key_n = 2'b11;
        end

        // Key 0 held for 50 edges: long press at edge 27, repeats every 5 when enabled.
        edge_n = 0;
        key_n  = 2'b10;
        for (int i = 0; i < 50; i++) begin
            step();
            check_eq($sformatf("t3 pulse e%0d", edge_n), key_pulse, {1'b0, rep_pulse(edge_n)});
            check_eq($sformatf("t3 level e%0d", edge_n), key_level, {1'b0, edge_n >= 7});
            check_eq($sformatf("t3 long e%0d", edge_n), key_long, {1'b0, edge_n >= 27});
        end
        key_n = 2'b11;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("t3r level e%0d", edge_n), key_level, {1'b0, edge_n < 57});
            check_eq($sformatf("t3r long e%0d", edge_n), key_long, {1'b0, edge_n < 57});
        end

        // Both keys pressed together.
        edge_n = 0;
        key_n  = 2'b00;
        for (int i = 0; i < 20; i++) begin
            step();
            check_eq($sformatf("t4 pulse e%0d", edge_n), key_pulse,
                     (edge_n == 7) ? 2'b11 : 2'b00);
            check_eq($sformatf("t4 level e%0d", edge_n), key_level,
                     ((edge_n >= 7) && (edge_n < 17)) ? 2'b11 : 2'b00);
            if (edge_n == 10) key_n = 2'b11;
        end

        // Reset at edge 30 while key 0 is in REPEAT; sync refills at 31-32, DEB_P at 33,
        // new pulse at 33 + DEB_CYC = 37.
        edge_n = 0;
        key_n  = 2'b10;
        repeat (29) step();
        check_eq("t5 long before rst", key_long, 2'b01);
        rst = 1'b1;
        step();
        check_eq("t5 rst pulse", key_pulse, 2'b00);
        check_eq("t5 rst level", key_level, 2'b00);
        check_eq("t5 rst long", key_long, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("t5 pulse e%0d", edge_n), key_pulse, {1'b0, edge_n == 37});
            check_eq($sformatf("t5 level e%0d", edge_n), key_level, {1'b0, edge_n >= 37});
            check_eq($sformatf("t5 long e%0d", edge_n), key_long, 2'b00);
        end
        key_n = 2'b11;
        repeat (10) step();
        check_eq("t5 final level", key_level, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
